water_valve_controller: RTL
===========================

WATER_VALVE_CONTROLLER -- requirements
Module: water_valve_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- AMOUNT_WIDTH, 14, width of amount and remaining in mL.
- MAX_AMOUNT, 9999, largest dispensable amount in mL (four decimal digits).
- ML_PER_PULSE, 5, mL delivered per flow-meter pulse.
- TIMEOUT_CYCLES, 50_000_000, no-flow limit in clock cycles.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- amount  in  AMOUNT_WIDTH  requested mL, sampled on start.
- start  in  1  one-cycle request pulse, synchronous to clock.
- cancel  in  1  one-cycle abort pulse, synchronous to clock.
- flow_pulse  in  1  raw asynchronous flow-meter output.
- valve_open  out  1  registered valve drive, 1 = open.
- busy  out  1  high in DISPENSE.
- remaining  out  AMOUNT_WIDTH  mL still to deliver.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on cancel.
- fault  out  1  no-flow fault flag.

Function
REQ-003 The FSM SHALL have the states IDLE, DISPENSE and FAULT; FAULT SHALL exist only when FLOW_TIMEOUT_EN is defined.
REQ-004 In IDLE, a start with 0 < amount SHALL load remaining with min(amount, MAX_AMOUNT) and enter DISPENSE; valve_open and busy SHALL rise on the next cycle.
REQ-005 A start with amount == 0 SHALL be ignored, and IDLE SHALL be held.
REQ-006 flow_pulse SHALL pass through a 2-FF synchronizer and a rising-edge detector, giving one counted edge per pulse; a raw rising edge SHALL be counted 3 cycles later.
REQ-007 In DISPENSE, each counted edge SHALL decrement remaining by ML_PER_PULSE, saturating at 0.
REQ-008 When remaining becomes 0, the next cycle SHALL drop valve_open and busy, pulse done for one cycle, and enter IDLE.
REQ-009 cancel in DISPENSE SHALL take priority over a flow edge in the same cycle, and that edge SHALL be discarded.
REQ-010 On cancel in DISPENSE, the next cycle SHALL close the valve, pulse aborted, hold remaining and enter IDLE.
REQ-011 start during DISPENSE or FAULT SHALL be ignored; cancel in IDLE SHALL have no effect.
REQ-012 Counted edges in IDLE SHALL be ignored.
REQ-013 remaining SHALL hold its last value in IDLE until the next accepted start.
REQ-014 done and aborted SHALL never be high in the same cycle.

Reset
REQ-015 reset SHALL force, asynchronously: state IDLE, valve_open=0, busy=0, remaining=0, done=0, aborted=0, fault=0, synchronizer and timeout counter cleared.
REQ-016 reset during DISPENSE SHALL close the valve immediately, with no done or aborted pulse.

Configuration
REQ-017 With FLOW_TIMEOUT_EN defined, a cycle counter SHALL clear on entry to DISPENSE and on each counted edge.
REQ-018 With FLOW_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES in DISPENSE SHALL enter FAULT with valve_open=0, busy=0, fault=1 and remaining held.
REQ-019 FAULT SHALL be left only by cancel (to IDLE, fault=0, aborted pulse) or by reset.
REQ-020 Without FLOW_TIMEOUT_EN, no counter SHALL be built and fault SHALL be tied to 0.

Structure
REQ-021 Package dispenser_pkg SHALL hold the state enumeration and the MAX_AMOUNT and ML_PER_PULSE defaults.
REQ-022 Sub-module flow_edge_sync SHALL implement the synchronizer and edge detector.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios:
- amount=20, start, 4 flow pulses -> remaining 15, 10, 5, 0; done pulses once; valve closes; remaining=0.
- amount=12, start, 3 pulses -> remaining 7, 2, 0 (saturates); done pulses.
- amount=0, start -> valve_open stays 0; busy stays 0.
- amount=100, start, 2 pulses, then cancel on the same cycle as a 3rd counted edge -> remaining=90; aborted pulses; no done.
- FLOW_TIMEOUT_EN with TIMEOUT_CYCLES=100, amount=50, start, no pulses -> fault=1 and valve closed at cycle 100; cancel -> fault=0, aborted pulses.
- reset asserted mid-DISPENSE -> valve_open=0 asynchronously; remaining=0; no pulses.

Source files
------------

// File: rtl/dispenser_pkg.sv
// Shared state type and amount/flow defaults for the water valve dispenser.
// The FAULT state is present only when FLOW_TIMEOUT_EN is defined.
package dispenser_pkg;

    localparam int DEF_MAX_AMOUNT   = 9999;
    localparam int DEF_ML_PER_PULSE = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1
`ifdef FLOW_TIMEOUT_EN
        ,
        FAULT    = 2'd2
`endif
    } state_e;

endpackage

// File: rtl/flow_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for the raw flow-meter output.
// edge_o is high for one cycle, two clock edges after the raw input rises.
module flow_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic pulse_i,
    output logic edge_o
);

    // [0],[1] form the synchronizer; [2] remembers the previous synchronized level.
    logic [2:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], pulse_i};
        end
    end

    assign edge_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/water_valve_controller.sv
// Dispenses a requested volume by opening a valve and counting flow-meter pulses.
// Define FLOW_TIMEOUT_EN to add the no-flow timeout and the FAULT state.
module water_valve_controller
    import dispenser_pkg::*;
#(
    parameter int AMOUNT_WIDTH   = 14,
    parameter int MAX_AMOUNT     = DEF_MAX_AMOUNT,
    parameter int ML_PER_PULSE   = DEF_ML_PER_PULSE,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [AMOUNT_WIDTH-1:0] amount,
    input  logic                    start,
    input  logic                    cancel,
    input  logic                    flow_pulse,
    output logic                    valve_open,
    output logic                    busy,
    output logic [AMOUNT_WIDTH-1:0] remaining,
    output logic                    done,
    output logic                    aborted,
    output logic                    fault
);

    localparam logic [AMOUNT_WIDTH-1:0] MAX_L  = AMOUNT_WIDTH'(MAX_AMOUNT);
    localparam logic [AMOUNT_WIDTH-1:0] STEP_L = AMOUNT_WIDTH'(ML_PER_PULSE);

    state_e                  state_q, state_d;
    logic [AMOUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                    valve_q;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;
    logic                    flow_edge;
    logic                    cnt_clear;
    logic                    timeout_hit;

    flow_edge_sync u_flow_edge_sync (
        .clock   (clock),
        .reset   (reset),
        .pulse_i (flow_pulse),
        .edge_o  (flow_edge)
    );

`ifdef FLOW_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             fault_q;

    // Counts cycles since DISPENSE entry or the last counted flow edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (cnt_clear) begin
            cnt_q <= '0;
        end else if (state_q == DISPENSE) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign timeout_hit = (state_q == DISPENSE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state_d == FAULT);
        end
    end

    assign fault = fault_q;
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign unused_cfg  = cnt_clear ^ (TIMEOUT_CYCLES != 0);
    assign fault       = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        cnt_clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && (amount != '0)) begin
                    remaining_d = (amount > MAX_L) ? MAX_L : amount;
                    state_d     = DISPENSE;
                    cnt_clear   = 1'b1;
                end
            end
            DISPENSE: begin
                // Cancel wins over a same-cycle flow edge, which is then dropped.
                if (cancel) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (remaining_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (flow_edge) begin
                    remaining_d = (remaining_q > STEP_L) ? (remaining_q - STEP_L) : '0;
                    cnt_clear   = 1'b1;
                end else if (timeout_hit) begin
`ifdef FLOW_TIMEOUT_EN
                    state_d = FAULT;
`endif
                end
            end
`ifdef FLOW_TIMEOUT_EN
            FAULT: begin
                if (cancel) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            valve_q     <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            valve_q     <= (state_d == DISPENSE);
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign valve_open = valve_q;
    assign busy       = (state_q == DISPENSE);
    assign remaining  = remaining_q;
    assign done       = done_q;
    assign aborted    = aborted_q;

endmodule
